// File: rtl/mac_pe_os_if.sv
// Operand/result bundle for one output-stationary MAC processing element.
// The master side (upstream array logic or bench) drives operands; the PE is the slave.
interface mac_pe_os_if #(
  parameter int IN_WORD_SIZE  = 8,
  parameter int OUT_WORD_SIZE = 16,
  parameter int CNT_WORD_SIZE = 8
);
  logic                     in_valid;
  logic                     in_last;
  logic                     signed_mode;
  logic [IN_WORD_SIZE-1:0]  a;
  logic [IN_WORD_SIZE-1:0]  b;
  logic [IN_WORD_SIZE-1:0]  a_fwd;
  logic [IN_WORD_SIZE-1:0]  b_fwd;
  logic                     fwd_valid;
  logic                     fwd_last;
  logic                     fwd_signed;
  logic [OUT_WORD_SIZE-1:0] out;
  logic                     out_valid;
  logic                     overflow;
  logic [CNT_WORD_SIZE-1:0] k_count;

  modport master (
    output in_valid, in_last, signed_mode, a, b,
    input  a_fwd, b_fwd, fwd_valid, fwd_last, fwd_signed,
    input  out, out_valid, overflow, k_count
  );

  modport slave (
    input  in_valid, in_last, signed_mode, a, b,
    output a_fwd, b_fwd, fwd_valid, fwd_last, fwd_signed,
    output out, out_valid, overflow, k_count
  );
endinterface

// File: rtl/mac_pe_os.sv
// Output-stationary MAC PE: forwards operands east/south and accumulates a*b
// over a framed dot-product, emitting one saturated, flagged result per sequence.
module mac_pe_os #(
  parameter int IN_WORD_SIZE  = 8,
  parameter int OUT_WORD_SIZE = 16,
  parameter int ACC_WORD_SIZE = 24,
  parameter int CNT_WORD_SIZE = 8
) (
  input  logic         clk,
  input  logic         clear_n,
  mac_pe_os_if.slave   bus
);
  localparam int PW = 2 * IN_WORD_SIZE;
  localparam logic signed [ACC_WORD_SIZE-1:0] SMAX =
    {{(ACC_WORD_SIZE-OUT_WORD_SIZE+1){1'b0}}, {(OUT_WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACC_WORD_SIZE-1:0] SMIN = ~SMAX;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic sat_clamped(input logic [ACC_WORD_SIZE-1:0] v, input logic sgn);
    if (sgn) return ($signed(v) > SMAX) || ($signed(v) < SMIN);
    return (v >> OUT_WORD_SIZE) != '0;
  endfunction

  function automatic logic [OUT_WORD_SIZE-1:0] sat_value(input logic [ACC_WORD_SIZE-1:0] v,
                                                         input logic sgn);
    if (sgn) begin
      if ($signed(v) > SMAX) return {1'b0, {(OUT_WORD_SIZE-1){1'b1}}};
      if ($signed(v) < SMIN) return {1'b1, {(OUT_WORD_SIZE-1){1'b0}}};
      return v[OUT_WORD_SIZE-1:0];
    end
    if ((v >> OUT_WORD_SIZE) != '0) return '1;
    return v[OUT_WORD_SIZE-1:0];
  endfunction

  state_t                      state, state_nxt;
  logic                        first_beat;

  logic [IN_WORD_SIZE-1:0]     a_p1, b_p1;
  logic                        vld_p1, last_p1, sgn_p1;
  logic [ACC_WORD_SIZE-1:0]    acc_p1;
  logic [CNT_WORD_SIZE-1:0]    cnt_p1;
  logic                        sticky_p1;
  logic                        mode_p1;
  logic [OUT_WORD_SIZE-1:0]    res_p1;
  logic                        res_ovf_p1;
  logic [CNT_WORD_SIZE-1:0]    res_cnt_p1;
  logic                        res_vld_p1;

  logic                        mode_eff;
  logic signed [PW-1:0]        a_s, b_s, prod_s;
  logic [PW-1:0]               a_u, b_u, prod_u;
  logic [ACC_WORD_SIZE-1:0]    prod_ext;
  logic [ACC_WORD_SIZE:0]      sum;
  logic                        add_ovf;
  logic [ACC_WORD_SIZE-1:0]    acc_nxt;
  logic [CNT_WORD_SIZE-1:0]    cnt_nxt;
  logic                        sticky_nxt;

  // ---- stage p0: product and accumulate (combinational) ----
  always_comb begin
    mode_eff = first_beat ? bus.signed_mode : mode_p1;
    a_s      = PW'($signed(bus.a));
    b_s      = PW'($signed(bus.b));
    a_u      = PW'(bus.a);
    b_u      = PW'(bus.b);
    prod_s   = a_s * b_s;
    prod_u   = a_u * b_u;
    prod_ext = mode_eff ? ACC_WORD_SIZE'(prod_s) : ACC_WORD_SIZE'(prod_u);
    sum      = {1'b0, acc_p1} + {1'b0, prod_ext};
    // Signed overflow: like-signed addends yielding a differently-signed sum.
    add_ovf  = mode_eff ? ((acc_p1[ACC_WORD_SIZE-1] == prod_ext[ACC_WORD_SIZE-1]) &&
                           (sum[ACC_WORD_SIZE-1] != acc_p1[ACC_WORD_SIZE-1]))
                        : sum[ACC_WORD_SIZE];
    acc_nxt    = first_beat ? prod_ext : sum[ACC_WORD_SIZE-1:0];
    cnt_nxt    = first_beat ? CNT_WORD_SIZE'(1) : cnt_p1 + CNT_WORD_SIZE'(1);
    sticky_nxt = first_beat ? 1'b0 : (sticky_p1 | add_ovf);
  end

  always_comb begin
    state_nxt  = state;
    first_beat = bus.in_valid && (state == IDLE);
    if (bus.in_valid) state_nxt = bus.in_last ? IDLE : ACCUM;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---- stage p1: forwarding, accumulator and result registers ----
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      a_p1       <= '0;
      b_p1       <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      sgn_p1     <= 1'b0;
      acc_p1     <= '0;
      cnt_p1     <= '0;
      sticky_p1  <= 1'b0;
      mode_p1    <= 1'b0;
      res_p1     <= '0;
      res_ovf_p1 <= 1'b0;
      res_cnt_p1 <= '0;
      res_vld_p1 <= 1'b0;
    end else begin
      vld_p1     <= bus.in_valid;
      last_p1    <= bus.in_valid & bus.in_last;
      res_vld_p1 <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        a_p1      <= bus.a;
        b_p1      <= bus.b;
        sgn_p1    <= bus.signed_mode;
        acc_p1    <= acc_nxt;
        cnt_p1    <= cnt_nxt;
        sticky_p1 <= sticky_nxt;
        mode_p1   <= mode_eff;
        if (bus.in_last) begin
          res_p1     <= sat_value(acc_nxt, mode_eff);
          res_ovf_p1 <= sat_clamped(acc_nxt, mode_eff) | sticky_nxt;
          res_cnt_p1 <= cnt_nxt;
        end
      end
    end
  end

  assign bus.a_fwd      = a_p1;
  assign bus.b_fwd      = b_p1;
  assign bus.fwd_valid  = vld_p1;
  assign bus.fwd_last   = last_p1;
  assign bus.fwd_signed = sgn_p1;
  assign bus.out        = res_p1;
  assign bus.out_valid  = res_vld_p1;
  assign bus.overflow   = res_ovf_p1;
  assign bus.k_count    = res_cnt_p1;
endmodule

// File: tb/tb_mac_pe_os.sv
// Directed bench for mac_pe_os: reset, bubbles, signed math, saturation,
// back-to-back sequences and first-beat mode latching.
module tb_mac_pe_os;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mac_pe_os_if #(.IN_WORD_SIZE(8), .OUT_WORD_SIZE(16), .CNT_WORD_SIZE(8)) bus ();

  mac_pe_os #(
    .IN_WORD_SIZE(8), .OUT_WORD_SIZE(16), .ACC_WORD_SIZE(24), .CNT_WORD_SIZE(8)
  ) dut (
    .clk(clk),
    .clear_n(clear_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic drive(input logic v, input logic l, input logic s,
                       input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid    = v;
    bus.in_last     = l;
    bus.signed_mode = s;
    bus.a           = av;
    bus.b           = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_reset();
    idle();
    idle();
    checks++; if ({bus.a_fwd, bus.b_fwd, bus.fwd_valid, bus.fwd_last, bus.fwd_signed} !== 19'd0) begin
      errors++; $display("FAIL reset_fwd: got %h want 0", {bus.a_fwd, bus.b_fwd, bus.fwd_valid, bus.fwd_last, bus.fwd_signed}); end
    checks++; if ({bus.out, bus.out_valid, bus.overflow, bus.k_count} !== 26'd0) begin
      errors++; $display("FAIL reset_res: got %h want 0", {bus.out, bus.out_valid, bus.overflow, bus.k_count}); end
    clear_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
    drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd6);
    checks++; if (bus.a_fwd !== 8'd5 || bus.b_fwd !== 8'd6) begin
      errors++; $display("FAIL pre_reset_fwd: got %0d,%0d want 5,6", bus.a_fwd, bus.b_fwd); end
    clear_n = 1'b0;
    idle();
    idle();
    clear_n = 1'b1;
    checks++; if ({bus.a_fwd, bus.b_fwd, bus.fwd_valid, bus.fwd_last, bus.out, bus.out_valid, bus.overflow, bus.k_count} !== 44'd0) begin
      errors++; $display("FAIL midseq_reset: got %h want 0", {bus.a_fwd, bus.b_fwd, bus.fwd_valid, bus.fwd_last, bus.out, bus.out_valid, bus.overflow, bus.k_count}); end
    idle();
    checks++; if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_result: got out_valid=%b want 0", bus.out_valid); end
    drive(1'b1, 1'b1, 1'b0, 8'd2, 8'd3);
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'd6 || bus.k_count !== 8'd1 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL single_beat: got v=%b out=%0d k=%0d ovf=%b want v=1 out=6 k=1 ovf=0", bus.out_valid, bus.out, bus.k_count, bus.overflow); end
    idle();
    checks++; if (bus.out_valid !== 1'b0 || bus.out !== 16'd6) begin
      errors++; $display("FAIL single_hold: got v=%b out=%0d want v=0 out=6", bus.out_valid, bus.out); end
  endtask

  task automatic test_unsigned_bubbles();
    drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd10);
    drive(1'b1, 1'b0, 1'b0, 8'd2, 8'd10);
    checks++; if (bus.fwd_valid !== 1'b1 || bus.a_fwd !== 8'd2 || bus.b_fwd !== 8'd10) begin
      errors++; $display("FAIL fwd_beat2: got vld=%b a=%0d b=%0d want 1,2,10", bus.fwd_valid, bus.a_fwd, bus.b_fwd); end
    drive(1'b0, 1'b1, 1'b1, 8'd99, 8'd77);
    checks++; if (bus.fwd_valid !== 1'b0 || bus.fwd_last !== 1'b0 || bus.a_fwd !== 8'd2 || bus.fwd_signed !== 1'b0) begin
      errors++; $display("FAIL bubble_hold: got vld=%b last=%b a=%0d sgn=%b want 0,0,2,0", bus.fwd_valid, bus.fwd_last, bus.a_fwd, bus.fwd_signed); end
    idle();
    checks++; if (bus.a_fwd !== 8'd2 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bubble2: got a=%0d v=%b want 2,0", bus.a_fwd, bus.out_valid); end
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd10);
    drive(1'b1, 1'b1, 1'b0, 8'd4, 8'd10);
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'd100 || bus.overflow !== 1'b0 || bus.k_count !== 8'd4) begin
      errors++; $display("FAIL unsigned_sum: got v=%b out=%0d ovf=%b k=%0d want 1,100,0,4", bus.out_valid, bus.out, bus.overflow, bus.k_count); end
    checks++; if (bus.fwd_last !== 1'b1 || bus.a_fwd !== 8'd4) begin
      errors++; $display("FAIL fwd_last: got last=%b a=%0d want 1,4", bus.fwd_last, bus.a_fwd); end
    idle();
  endtask

  task automatic test_signed();
    drive(1'b1, 1'b0, 1'b1, 8'(-3), 8'd5);
    drive(1'b1, 1'b0, 1'b1, 8'd2, 8'(-7));
    drive(1'b1, 1'b1, 1'b1, 8'(-1), 8'(-1));
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'hFFE4 || bus.overflow !== 1'b0 || bus.k_count !== 8'd3) begin
      errors++; $display("FAIL signed_sum: got v=%b out=%h ovf=%b k=%0d want 1,ffe4,0,3", bus.out_valid, bus.out, bus.overflow, bus.k_count); end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) drive(1'b1, i == 2, 1'b0, 8'd255, 8'd255);
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'hFFFF || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL sat_unsigned: got v=%b out=%h ovf=%b want 1,ffff,1", bus.out_valid, bus.out, bus.overflow); end
    idle();
    for (int i = 0; i < 3; i++) drive(1'b1, i == 2, 1'b1, 8'd127, 8'd127);
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'h7FFF || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL sat_signed_pos: got v=%b out=%h ovf=%b want 1,7fff,1", bus.out_valid, bus.out, bus.overflow); end
    idle();
    for (int i = 0; i < 3; i++) drive(1'b1, i == 2, 1'b1, 8'(-128), 8'd127);
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'h8000 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL sat_signed_neg: got v=%b out=%h ovf=%b want 1,8000,1", bus.out_valid, bus.out, bus.overflow); end
    idle();
    // Exactly at the upper bounds: no clamp.
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd255);
    drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd2);
    checks++; if (bus.out !== 16'hFFFF || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL edge_unsigned: got out=%h ovf=%b want ffff,0", bus.out, bus.overflow); end
    drive(1'b1, 1'b0, 1'b1, 8'(-128), 8'(-128));
    drive(1'b1, 1'b0, 1'b1, 8'd127, 8'd127);
    drive(1'b1, 1'b1, 1'b1, 8'd127, 8'd2);
    checks++; if (bus.out !== 16'h7FFF || bus.overflow !== 1'b0 || bus.k_count !== 8'd3) begin
      errors++; $display("FAIL edge_signed: got out=%h ovf=%b k=%0d want 7fff,0,3", bus.out, bus.overflow, bus.k_count); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
    drive(1'b1, 1'b1, 1'b0, 8'd3, 8'd3);
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'd13 || bus.k_count !== 8'd2) begin
      errors++; $display("FAIL b2b_first: got v=%b out=%0d k=%0d want 1,13,2", bus.out_valid, bus.out, bus.k_count); end
    drive(1'b1, 1'b1, 1'b0, 8'd4, 8'd4);
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'd16 || bus.k_count !== 8'd1) begin
      errors++; $display("FAIL b2b_second: got v=%b out=%0d k=%0d want 1,16,1", bus.out_valid, bus.out, bus.k_count); end
    idle();
    checks++; if (bus.out_valid !== 1'b0 || bus.out !== 16'd16) begin
      errors++; $display("FAIL b2b_drop: got v=%b out=%0d want 0,16", bus.out_valid, bus.out); end
  endtask

  task automatic test_mode_latch();
    drive(1'b1, 1'b0, 1'b1, 8'(-1), 8'd1);
    checks++; if (bus.fwd_signed !== 1'b1) begin
      errors++; $display("FAIL fwd_signed_1: got %b want 1", bus.fwd_signed); end
    drive(1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    checks++; if (bus.fwd_signed !== 1'b0) begin
      errors++; $display("FAIL fwd_signed_0: got %b want 0", bus.fwd_signed); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out !== 16'd0 || bus.overflow !== 1'b0 || bus.k_count !== 8'd2) begin
      errors++; $display("FAIL mode_latch: got v=%b out=%h ovf=%b k=%0d want 1,0000,0,2", bus.out_valid, bus.out, bus.overflow, bus.k_count); end
    idle();
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = 8'd0;
    bus.b           = 8'd0;
    test_reset();
    test_unsigned_bubbles();
    test_signed();
    test_saturation();
    test_back_to_back();
    test_mode_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_pe_os.md
Name: mac_pe_os

Overview:
- Parametrised output-stationary MAC processing element for the systolic matrix-multiply array. Next generation of the 8-bit/16-bit MAC cell.
- Each cycle it forwards operands and a valid/last tag to its east/south neighbours, and accumulates a*b over a variable-length dot-product sequence.
- On the last beat it emits one saturated, flagged result with valid and beat count.
- Adds over the previous cell: valid gating, sequence framing, signed/unsigned mode, wide accumulator and output saturation.

Parameters:
- IN_WORD_SIZE, 8, operand width (bits) of a and b.
- OUT_WORD_SIZE, 16, result width (bits) of out.
- ACC_WORD_SIZE, 24, internal accumulator width. Must be ≥ 2*IN_WORD_SIZE and ≥ OUT_WORD_SIZE.
- CNT_WORD_SIZE, 8, width of the beat counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clear_n  in  1  synchronous active-low reset.
- in_valid  in  1  a, b, in_last, signed_mode are valid this cycle.
- in_last  in  1  final beat of the current dot-product sequence.
- signed_mode  in  1  1 = two's-complement operands/result; 0 = unsigned.
- a  in  IN_WORD_SIZE  row operand.
- b  in  IN_WORD_SIZE  column operand.
- a_fwd  out  IN_WORD_SIZE  registered a to east neighbour.
- b_fwd  out  IN_WORD_SIZE  registered b to south neighbour.
- fwd_valid  out  1  registered in_valid.
- fwd_last  out  1  registered in_last & in_valid.
- fwd_signed  out  1  registered signed_mode.
- out  out  OUT_WORD_SIZE  saturated result.
- out_valid  out  1  one-cycle pulse: out/overflow/k_count valid.
- overflow  out  1  result was clamped, or accumulator wrapped during the sequence.
- k_count  out  CNT_WORD_SIZE  number of valid beats in the emitted sequence (wraps modulo 2^CNT_WORD_SIZE).

Behaviour:
- Reset: while clear_n=0 at a rising edge, all outputs, acc, beat counter, sticky overflow and mode latch go to 0, and state returns to IDLE. Reset mid-sequence discards the partial sum with no out_valid.
- Forwarding, latency 1:
  - fwd_valid<=in_valid and fwd_last<=in_valid&in_last every cycle.
  - a_fwd, b_fwd, fwd_signed load only when in_valid=1; otherwise they hold.
- States:
  - IDLE: no open sequence.
  - ACCUM: sequence open.
- Transitions:
  - IDLE + in_valid & !in_last -> ACCUM.
  - IDLE + in_valid & in_last -> IDLE (single-beat sequence, result emitted).
  - ACCUM + in_valid & in_last -> IDLE.
  - Otherwise the state holds.
- Mode latch: signed_mode is captured on the first beat (in_valid in IDLE) and used for the whole sequence. signed_mode on later beats is ignored for arithmetic but still forwarded.
- Product: a*b is computed as a 2*IN_WORD_SIZE-bit value (signed or unsigned per the latched mode), then sign- or zero-extended to ACC_WORD_SIZE.
- First beat: acc<=product; cnt<=1; sticky overflow<=0.
- Later beats: acc<=acc+product, modulo 2^ACC_WORD_SIZE; cnt<=cnt+1.
  - Sticky overflow sets if the addition overflows ACC_WORD_SIZE: signed overflow in signed mode, carry-out in unsigned mode.
- in_valid=0: acc, cnt, state and sticky flag hold (bubble). No timeout.
- Result, on the cycle after the beat with in_valid & in_last:
  - out_valid=1 for exactly one cycle.
  - out = final acc (including the last product) clamped to the OUT_WORD_SIZE range:
    - signed: [-2^(OUT-1), 2^(OUT-1)-1]
    - unsigned: [0, 2^OUT-1]
  - overflow = clamp occurred OR sticky flag.
  - k_count = final count.
  - out, overflow and k_count hold their values until the next result; out_valid drops to 0.
- Back-to-back: a new sequence's first beat may arrive on the cycle right after in_last. No dead cycles are required; results can pulse on consecutive cycles.

Test Plan:
- Reset: drive clear_n=0 for 2 cycles mid-sequence after beats (3,4),(5,6), then release -> all outputs 0, no out_valid. A subsequent single beat (2,3,last) -> out=6, k_count=1, out_valid one cycle later.
- Unsigned 4-beat with bubbles, signed_mode=0: a=1..4, b=10 each, in_valid low between beats 2 and 3 for 2 cycles -> out=100, overflow=0, k_count=4. fwd_valid mirrors in_valid with 1-cycle delay; a_fwd holds 2 during the bubble.
- Signed: signed_mode=1, beats (-3,5),(2,-7),(-1,-1,last) -> out=-28 (0xFFE4), overflow=0.
- Saturation unsigned: 3 beats of (255,255), last -> acc=195075 -> out=65535, overflow=1. Signed: 3 beats of (127,127) -> acc=48387 -> out=32767, overflow=1. Signed: 3 beats of (-128,127) -> out=-32768, overflow=1.
- Back-to-back: sequence A (2,2),(3,3,last) immediately followed by B (4,4,last) -> out_valid on 2 consecutive cycles with out=13 then 16, k_count 2 then 1.
- Mode latch: first beat signed_mode=1 (a=-1,b=1), second beat signed_mode=0 (a=1,b=1,last) -> out=0 (signed arithmetic kept); fwd_signed shows 1 then 0.
